// File: rtl/anf_fl_tex_pkg.sv
// anf_fl_tex_pkg: shared texture-path formats, packet geometry and texel widths
package anf_fl_tex_pkg;
  localparam int PKT_W = 128;
  typedef enum logic [1:0] {
    FMT_RGBA8888 = 2'd0,
    FMT_RGB565   = 2'd1,
    FMT_RGBA4444 = 2'd2,
    FMT_L8       = 2'd3
  } tex_fmt_e;
  localparam int TPP_RGBA8888 = 4;
  localparam int TPP_RGB565 = 8;
  localparam int TPP_RGBA4444 = 8;
  localparam int TPP_L8 = 16;
  localparam int TW_RGBA8888 = 32;
  localparam int TW_RGB565 = 16;
  localparam int TW_RGBA4444 = 16;
  localparam int TW_L8 = 8;
  function automatic logic [4:0] texels_per_pkt(input tex_fmt_e f);
    return f == FMT_L8 ? 5'(TPP_L8) : f == FMT_RGBA8888 ? 5'(TPP_RGBA8888) :
           f == FMT_RGB565 ? 5'(TPP_RGB565) : 5'(TPP_RGBA4444);
  endfunction
endpackage

// File: rtl/anf_fl_tex_fmt_conv.sv
// anf_fl_tex_fmt_conv: combinational texel select + RGBA8888 expansion
// Optional colour key (alpha forced to 00 on RGB match) under ANFFL_TEX_COLORKEY_EN.
module anf_fl_tex_fmt_conv
  import anf_fl_tex_pkg::*;
(
  input  logic [PKT_W-1:0] pkt,
  input  tex_fmt_e         fmt,
  input  logic [3:0]       idx,
`ifdef ANFFL_TEX_COLORKEY_EN
  input  logic [23:0]      colorkey_rgb,
  input  logic             colorkey_en,
`endif
  output logic [31:0]      rgba
);
  logic [6:0] sh;
  logic [31:0] t;
  logic [31:0] conv;
  always_comb begin
    sh = fmt == FMT_L8 ? {idx, 3'b0} : fmt == FMT_RGBA8888 ? {idx[1:0], 5'b0} : {idx[2:0], 4'b0};
    t = 32'(pkt >> sh);
    conv = fmt == FMT_RGBA8888 ? t :
           fmt == FMT_RGB565 ? {t[15:11], t[15:13], t[10:5], t[10:9], t[4:0], t[4:2], 8'hff} :
           fmt == FMT_RGBA4444 ? {{2{t[15:12]}}, {2{t[11:8]}}, {2{t[7:4]}}, {2{t[3:0]}}} :
           {{3{t[7:0]}}, 8'hff};
`ifdef ANFFL_TEX_COLORKEY_EN
    rgba = colorkey_en && conv[31:8] == colorkey_rgb ? {conv[31:8], 8'h00} : conv;
`else
    rgba = conv;
`endif
  end
endmodule

// File: rtl/anf_fl_tex_texel_unpack.sv
// anf_fl_tex_texel_unpack: holds a fetched packet and streams its texel span as RGBA8888
// Optional colour-key ports under ANFFL_TEX_COLORKEY_EN.
module anf_fl_tex_texel_unpack
  import anf_fl_tex_pkg::*;
#(
  parameter int CNT_W = 5,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic [PKT_W-1:0] pkt_data,
  input  logic [1:0]       pkt_fmt,
  input  logic [IDX_W-1:0] pkt_start,
  input  logic [CNT_W-1:0] pkt_count,
  output logic             texel_valid,
  input  logic             texel_ready,
  output logic [31:0]      texel_rgba,
  output logic             texel_last,
  output logic             span_trunc
`ifdef ANFFL_TEX_COLORKEY_EN
  ,
  input  logic [23:0]      colorkey_rgb,
  input  logic             colorkey_en
`endif
);
  typedef enum logic {IDLE, EMIT} state_e;
  state_e state, state_nx;
  logic [PKT_W-1:0] pkt_q;
  tex_fmt_e fmt_q, fmt_in;
  logic [IDX_W-1:0] idx_q, start_m;
  logic [CNT_W-1:0] rem_q, n, avail, emit_cnt;
  logic trunc_q, trunc, accept, fire;
  assign texel_valid = state == EMIT;
  assign texel_last = texel_valid && rem_q == CNT_W'(1);
  assign span_trunc = texel_last && trunc_q;
  // The next packet may enter in the same cycle the final texel leaves.
  assign pkt_ready = reset && (state == IDLE || (texel_last && texel_ready));
  always_comb begin
    fmt_in = tex_fmt_e'(pkt_fmt);
    n = CNT_W'(texels_per_pkt(fmt_in));
    start_m = pkt_start & IDX_W'(n - CNT_W'(1));
    avail = n - CNT_W'(start_m);
    trunc = pkt_count > avail;
    emit_cnt = trunc ? avail : pkt_count;
    accept = pkt_valid && pkt_ready;
    fire = texel_valid && texel_ready;
    state_nx = accept ? (emit_cnt != '0 ? EMIT : IDLE) : fire && texel_last ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pkt_q <= '0;
      fmt_q <= FMT_RGBA8888;
      idx_q <= '0;
      rem_q <= '0;
      trunc_q <= 1'b0;
    end else if (accept && emit_cnt != '0) begin
      pkt_q <= pkt_data;
      fmt_q <= fmt_in;
      idx_q <= start_m;
      rem_q <= emit_cnt;
      trunc_q <= trunc;
    end else if (fire && !texel_last) begin
      idx_q <= idx_q + 1'b1;
      rem_q <= rem_q - 1'b1;
    end
  anf_fl_tex_fmt_conv u_conv (
    .pkt(pkt_q),
    .fmt(fmt_q),
    .idx(4'(idx_q)),
`ifdef ANFFL_TEX_COLORKEY_EN
    .colorkey_rgb(colorkey_rgb),
    .colorkey_en(colorkey_en),
`endif
    .rgba(texel_rgba)
  );
endmodule

// File: tb/tb_anf_fl_tex_texel_unpack.sv
// tb_anf_fl_tex_texel_unpack: directed + randomized bench against a texel-queue reference model
module tb_anf_fl_tex_texel_unpack;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pkt_valid = 1'b0;
  logic pkt_ready;
  logic [127:0] pkt_data = '0;
  logic [1:0] pkt_fmt = '0;
  logic [3:0] pkt_start = '0;
  logic [4:0] pkt_count = '0;
  logic texel_valid;
  logic texel_ready = 1'b1;
  logic [31:0] texel_rgba;
  logic texel_last;
  logic span_trunc;
  typedef struct packed {
    logic [31:0] rgba;
    logic last;
    logic trunc;
  } exp_t;
  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  bit acc;
  int rdy_mode = 0;
  int pat_i = 0;
  bit [3:0] pat = 4'b1001;
  always #5 clk = ~clk;
  anf_fl_tex_texel_unpack dut (
    .clk(clk),
    .reset(reset),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_data(pkt_data),
    .pkt_fmt(pkt_fmt),
    .pkt_start(pkt_start),
    .pkt_count(pkt_count),
    .texel_valid(texel_valid),
    .texel_ready(texel_ready),
    .texel_rgba(texel_rgba),
    .texel_last(texel_last),
    .span_trunc(span_trunc)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Channel expansion written as arithmetic: x*2^k + x>>(bits-k) replicates the top bits.
  function automatic logic [31:0] model_texel(input logic [127:0] d, input int f, input int i);
    int w, t, r, g, b, a;
    logic [127:0] s;
    w = f == 0 ? 32 : f == 3 ? 8 : 16;
    s = d >> (i * w);
    t = int'({16'b0, s[15:0]});
    if (f == 0) return s[31:0];
    if (f == 1) begin
      r = t / 2048; g = (t / 32) % 64; b = t % 32;
      return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4), 8'hff};
    end
    if (f == 2) begin
      r = t / 4096; g = (t / 256) % 16; b = (t / 16) % 16; a = t % 16;
      return {8'(r * 17), 8'(g * 17), 8'(b * 17), 8'(a * 17)};
    end
    return {s[7:0], s[7:0], s[7:0], 8'hff};
  endfunction
  task automatic push_model();
    int n, st, av, e;
    bit tr;
    exp_t x;
    n = pkt_fmt == 2'd0 ? 4 : pkt_fmt == 2'd3 ? 16 : 8;
    st = int'(pkt_start) % n;
    av = n - st;
    tr = int'(pkt_count) > av;
    e = tr ? av : int'(pkt_count);
    for (int k = 0; k < e; k++) begin
      x.rgba = model_texel(pkt_data, int'(pkt_fmt), st + k);
      x.last = k == e - 1;
      x.trunc = (k == e - 1) && tr;
      q.push_back(x);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    acc = 0;
    if (reset) begin
      chk("texel_valid", 32'(texel_valid), 32'(q.size() != 0));
      chk("pkt_ready", 32'(pkt_ready), 32'(q.size() == 0 || (q.size() == 1 && texel_ready)));
      if (texel_valid && q.size() != 0) begin
        chk("texel_rgba", texel_rgba, q[0].rgba);
        chk("texel_last", 32'(texel_last), 32'(q[0].last));
        chk("span_trunc", 32'(span_trunc), 32'(q[0].trunc));
        if (texel_ready) void'(q.pop_front());
      end
      if (pkt_valid && pkt_ready) begin
        acc = 1;
        push_model();
      end
    end
    @(posedge clk);
    #1;
    texel_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : pat[pat_i % 4];
    pat_i++;
  endtask
  task automatic send(input logic [127:0] d, input logic [1:0] f, input logic [3:0] s,
                      input logic [4:0] c, output int waited);
    pkt_data = d; pkt_fmt = f; pkt_start = s; pkt_count = c;
    pkt_valid = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!acc && waited < 200);
    chk("accept", 32'(acc), 32'd1);
    pkt_valid = 1'b0;
  endtask
  task automatic drain();
    int i = 0;
    while (q.size() != 0 && i < 400) begin
      tick();
      i++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    tick();
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int w;
    logic [127:0] d;
    #12;
    chk("rst_valid", 32'(texel_valid), 32'd0);
    chk("rst_pkt_ready", 32'(pkt_ready), 32'd0);
    chk("rst_rgba", texel_rgba, 32'd0);
    chk("rst_last", 32'(texel_last), 32'd0);
    chk("rst_trunc", 32'(span_trunc), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    d = rnd128(); d[63:32] = 32'h11223344;
    send(d, 2'd0, 4'd1, 5'd1, w);
    drain();
    d = rnd128(); d[15:0] = 16'hF800;
    send(d, 2'd1, 4'd0, 5'd8, w);
    drain();
    send(rnd128(), 2'd3, 4'd14, 5'd5, w);
    drain();
    send(rnd128(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 5'd0, w);
    send(rnd128(), 2'd0, 4'd0, 5'd2, w);
    chk("cnt0_next_accept_wait", 32'(w), 32'd1);
    drain();
    rdy_mode = 2;
    pat_i = 0;
    d = rnd128(); d[15:0] = 16'hA5C3;
    send(d, 2'd2, 4'd0, 5'd4, w);
    drain();
    rdy_mode = 0;
    send(rnd128(), 2'd1, 4'd0, 5'd8, w);
    for (int i = 0; i < 20 && q.size() > 6; i++) tick();
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(texel_valid), 32'd0);
    chk("midrst_pkt_ready", 32'(pkt_ready), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) tick();
    send(rnd128(), 2'd2, 4'd3, 5'd3, w);
    drain();
    rdy_mode = 1;
    for (int p = 0; p < 300; p++) begin
      send(rnd128(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 20)), w);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
